// File: rtl/img_stream_out.sv
// Streams a finished image out of a single-port BRAM in raster order; a pixel reaches valid_out READ_LATENCY+1 cycles after its read issues.
// Reads issue only while buffered + in-flight < FIFO_DEPTH, so ready_in may stall indefinitely with no loss.
module img_stream_out #(
  parameter int BIT_DEPTH    = 8,
  parameter int WIDTH        = 64,
  parameter int HEIGHT       = 64,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            start_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0] read_addr,
  output logic                            read_addr_valid,
  input  logic [BIT_DEPTH-1:0]            pixel_in,
  output logic [BIT_DEPTH-1:0]            pixel_out,
  output logic [$clog2(WIDTH)-1:0]        pixel_x_out,
  output logic [$clog2(HEIGHT)-1:0]       pixel_y_out,
  output logic                            valid_out,
  input  logic                            ready_in,
  output logic                            last_out,
  output logic                            busy_out,
  output logic                            done_out
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          last;
  } tag_t;

  typedef struct packed {
    logic [BIT_DEPTH-1:0] pix;
    tag_t                 tag;
  } entry_t;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t              state, state_nxt;
  logic                done_nxt;
  logic                done_r;
  logic [AW-1:0]       addr;
  logic [XW-1:0]       x_cnt;
  logic [YW-1:0]       y_cnt;
  logic [READ_LATENCY-1:0] sr;
  tag_t                tag_pipe [READ_LATENCY];
  entry_t              mem [FIFO_DEPTH];
  entry_t              head;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count, in_flight;
  logic                issue, push, pop, start_go, addr_is_last;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) in_flight = in_flight + CW'(sr[i]);
  end

  // Same-cycle pops are deliberately not credited, keeping issue off the ready_in path.
  assign issue        = (state == READ) && ((count + in_flight) < CW'(FIFO_DEPTH));
  assign push         = sr[READ_LATENCY-1];
  assign head         = mem[rd_ptr];
  assign valid_out    = (count != '0);
  assign pop          = valid_out && ready_in;
  assign start_go     = (state == IDLE) && start_in;
  assign addr_is_last = (addr == AW'(N - 1));

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:  if (start_in) state_nxt = READ;
      READ:  if (issue && addr_is_last) state_nxt = DRAIN;
      DRAIN: if (pop && head.tag.last) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state  <= IDLE;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= done_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      addr  <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
      sr    <= '0;
    end else if (start_go) begin
      addr  <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
      sr    <= '0;
    end else begin
      sr <= (sr << 1) | READ_LATENCY'(issue);
      if (issue) begin
        addr <= addr + AW'(1);
        if (x_cnt == XW'(WIDTH - 1)) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + YW'(1);
        end else begin
          x_cnt <= x_cnt + XW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    tag_pipe[0] <= '{x: x_cnt, y: y_cnt, last: addr_is_last};
    for (int i = 1; i < READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    if (push) mem[wr_ptr] <= '{pix: pixel_in, tag: tag_pipe[READ_LATENCY-1]};
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (start_go) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assert property (@(posedge clk_in) disable iff (!rst_in) !(push && (count == CW'(FIFO_DEPTH))));

  // Gate the head with valid so stale RAM contents never leak out after reset.
  assign pixel_out       = valid_out ? head.pix   : '0;
  assign pixel_x_out     = valid_out ? head.tag.x : '0;
  assign pixel_y_out     = valid_out ? head.tag.y : '0;
  assign last_out        = valid_out && head.tag.last;
  assign read_addr       = addr;
  assign read_addr_valid = issue;
  assign busy_out        = (state != IDLE);
  assign done_out        = done_r;

endmodule

// File: tb/tb_img_stream_out.sv
// Bench for img_stream_out: 4x4 frames under several ready patterns, a mid-frame reset, and an 8x2 deeper-latency instance.
`timescale 1ns/1ps
module tb_img_stream_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       start_a, rvld_a, vld_a, rdy_a, last_a, busy_a, done_a;
  logic [3:0] raddr_a;
  logic [7:0] pin_a, pix_a;
  logic [1:0] x_a, y_a;

  logic       start_b, rvld_b, vld_b, rdy_b, last_b, busy_b, done_b;
  logic [3:0] raddr_b;
  logic [7:0] pin_b, pix_b;
  logic [2:0] x_b;
  logic [0:0] y_b;

  img_stream_out #(.BIT_DEPTH(8), .WIDTH(4), .HEIGHT(4), .READ_LATENCY(2), .FIFO_DEPTH(4)) dut_a (
    .clk_in(clk), .rst_in(rst_n), .start_in(start_a), .read_addr(raddr_a), .read_addr_valid(rvld_a),
    .pixel_in(pin_a), .pixel_out(pix_a), .pixel_x_out(x_a), .pixel_y_out(y_a), .valid_out(vld_a),
    .ready_in(rdy_a), .last_out(last_a), .busy_out(busy_a), .done_out(done_a));

  img_stream_out #(.BIT_DEPTH(8), .WIDTH(8), .HEIGHT(2), .READ_LATENCY(3), .FIFO_DEPTH(5)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .start_in(start_b), .read_addr(raddr_b), .read_addr_valid(rvld_b),
    .pixel_in(pin_b), .pixel_out(pix_b), .pixel_x_out(x_b), .pixel_y_out(y_b), .valid_out(vld_b),
    .ready_in(rdy_b), .last_out(last_b), .busy_out(busy_b), .done_out(done_b));

  // BRAM models preloaded with addr*3, one register per latency cycle.
  logic [7:0] pa [2];
  logic [7:0] pb [3];
  always @(posedge clk) begin
    pa[0] <= 8'(raddr_a) * 8'd3;
    pa[1] <= pa[0];
    pb[0] <= 8'(raddr_b) * 8'd3;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign pin_a = pa[1];
  assign pin_b = pb[2];

  typedef struct { int pix; int x; int y; int last; } exp_t;
  typedef struct { int mode; int mid; int exp_fv; int exp_lc; int exp_dc; } scen_t;

  exp_t sb[$];
  exp_t sb_b[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc, issued, popped, fv, lc, dc, bfirst, blast;
  bit prev_stall;
  logic [7:0] prev_pix;
  logic [4:0] prev_tag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input int w, input bit to_b);
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      e.pix = i * 3; e.x = i % w; e.y = i / w; e.last = (i == 15) ? 1 : 0;
      if (to_b) sb_b.push_back(e); else sb.push_back(e);
    end
  endtask

  task automatic step_a(input bit r);
    exp_t e;
    @(posedge clk); #1;
    cyc++;
    rdy_a = r;
    if (prev_stall) begin
      check("hold_pix", pix_a, prev_pix);
      check("hold_tag", {x_a, y_a, last_a}, prev_tag);
    end
    if (rvld_a) begin
      check("credit_room", 32'((issued - popped) < 4), 1);
      issued++;
    end
    if (vld_a && fv < 0) fv = cyc;
    if (busy_a) begin
      if (bfirst < 0) bfirst = cyc;
      blast = cyc;
    end
    if (done_a && dc < 0) dc = cyc;
    if (vld_a && rdy_a) begin
      if (sb.size() == 0) check("extra_pixel", 1, 0);
      else begin
        e = sb.pop_front();
        check("pix", pix_a, e.pix);
        check("x", x_a, e.x);
        check("y", y_a, e.y);
        check("last", last_a, e.last);
      end
      if (last_a) lc = cyc;
      popped++;
    end
    prev_stall = vld_a && !rdy_a;
    prev_pix   = pix_a;
    prev_tag   = {x_a, y_a, last_a};
  endtask

  // mode 0: ready high; 1: random; 2: ready low for cycles 1..30
  task automatic run_frame_a(input int mode, input int mid);
    bit r;
    fv = -1; lc = -1; dc = -1; bfirst = -1; blast = -1;
    issued = 0; popped = 0; prev_stall = 0; cyc = 0;
    sb.delete();
    push_frame(4, 1'b0);
    start_a = 1'b1;
    for (int i = 0; i < 600 && dc < 0; i++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (cyc >= 30);
      endcase
      step_a(r);
      start_a = (cyc == mid);
      if (mode == 2 && cyc == 30) begin
        check("stall_reads", issued, 4);
        check("stall_valid", vld_a, 1);
        check("stall_pix0", pix_a, 0);
      end
    end
    if (dc < 0) check("done_timeout", 0, 1);
    start_a = 1'b0;
    step_a(1'b1);
    check("done_pulse", done_a, 0);
    check("busy_after", busy_a, 0);
    check("no_drop", sb.size(), 0);
    check("pop_count", popped, 16);
    check("busy_first", bfirst, 1);
    check("busy_last", blast, dc - 1);
  endtask

  task automatic run_frame_b();
    exp_t e;
    int fvb, lcb, dcb, popb;
    fvb = -1; lcb = -1; dcb = -1; popb = 0; cyc = 0;
    sb_b.delete();
    push_frame(8, 1'b1);
    start_b = 1'b1;
    for (int i = 0; i < 200 && dcb < 0; i++) begin
      @(posedge clk); #1;
      cyc++;
      start_b = 1'b0;
      if (vld_b && fvb < 0) fvb = cyc;
      if (done_b) dcb = cyc;
      if (vld_b && rdy_b) begin
        if (sb_b.size() == 0) check("b_extra_pixel", 1, 0);
        else begin
          e = sb_b.pop_front();
          check("b_pix", pix_b, e.pix);
          check("b_xy", {x_b, y_b}, {3'(e.x), 1'(e.y)});
          check("b_last", last_b, e.last);
        end
        if (last_b) lcb = cyc;
        popb++;
      end
    end
    check("b_first_valid", fvb, 5);
    check("b_last_cycle", lcb, 20);
    check("b_done_cycle", dcb, 21);
    check("b_pop_count", popb, 16);
  endtask

  initial begin
    scen_t tbl [4];
    tbl[0] = '{0, -1, 4, 19, 20};
    tbl[1] = '{1, -1, 4, -1, -1};
    tbl[2] = '{2, -1, 4, 46, 47};
    tbl[3] = '{0,  8, 4, 19, 20};

    rst_n = 1'b0; start_a = 1'b0; rdy_a = 1'b0; start_b = 1'b0; rdy_b = 1'b1;
    cyc = 0;
    #1;
    check("reset_outs_a", {raddr_a, rvld_a, pix_a, x_a, y_a, vld_a, last_a, busy_a, done_a}, 0);
    check("reset_outs_b", {raddr_b, rvld_b, pix_b, x_b, y_b, vld_b, last_b, busy_b, done_b}, 0);
    #20;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_frame_a(tbl[i].mode, tbl[i].mid);
      check("first_valid", fv, tbl[i].exp_fv);
      if (tbl[i].exp_lc >= 0) check("last_cycle", lc, tbl[i].exp_lc);
      if (tbl[i].exp_dc >= 0) check("done_cycle", dc, tbl[i].exp_dc);
    end

    // Asynchronous reset while pixel 7 sits on the output.
    cyc = 0; issued = 0; popped = 0; prev_stall = 0; fv = -1; dc = -1; bfirst = -1;
    sb.delete();
    push_frame(4, 1'b0);
    start_a = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step_a(1'b1);
      start_a = 1'b0;
    end
    check("pre_reset_pix7", pix_a, 21);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {raddr_a, rvld_a, pix_a, x_a, y_a, vld_a, last_a, busy_a, done_a}, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame_a(0, -1);
    check("post_rst_first_valid", fv, 4);
    check("post_rst_last_cycle", lc, 19);
    check("post_rst_done_cycle", dc, 20);

    run_frame_b();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/img_stream_out.md
# img_stream_out

Reads a finished image (e.g. a blurred octave) back out of a single-port BRAM in raster order and presents it as a pixel stream with valid/ready backpressure. It is the consumer-side counterpart of the blur stage: blur writes its output BRAM, and this block reads that BRAM for downstream stages such as DoG, downsampling or UART dump. It hides the BRAM read latency behind a small credit-controlled FIFO, so it sustains one pixel per cycle while `ready_in` stays high.

## Interface

Parameters:
- `BIT_DEPTH`, 8: bits per pixel.
- `WIDTH`, 64: image width in pixels.
- `HEIGHT`, 64: image height in pixels.
- `READ_LATENCY`, 2: cycles from `read_addr_valid` to `pixel_in` being valid.
- `FIFO_DEPTH`, 4: output buffer entries. Must be ≥ `READ_LATENCY`+2.

Ports:
- `clk_in`  in  1  single clock.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `start_in`  in  1  one-cycle pulse that begins a full-frame readout.
- `read_addr`  out  $clog2(WIDTH*HEIGHT)  BRAM read address.
- `read_addr_valid`  out  1  read issued this cycle.
- `pixel_in`  in  BIT_DEPTH  BRAM read data.
- `pixel_out`  out  BIT_DEPTH  stream data.
- `pixel_x_out`  out  $clog2(WIDTH)  column of `pixel_out`.
- `pixel_y_out`  out  $clog2(HEIGHT)  row of `pixel_out`.
- `valid_out`  out  1  stream data valid.
- `ready_in`  in  1  downstream accepts.
- `last_out`  out  1  high with the final pixel (x=WIDTH-1, y=HEIGHT-1).
- `busy_out`  out  1  readout in progress.
- `done_out`  out  1  one-cycle pulse after the final handshake.

## Operation

- States:
  - IDLE. `start_in` moves the block to READ and clears the issue address, the FIFO and the in-flight pipe.
  - READ. Reads are issued until address WIDTH*HEIGHT-1 has been issued, then the block moves to DRAIN.
  - DRAIN. Waits for the final handshake, then moves to IDLE and pulses `done_out`.
- `start_in` is ignored outside IDLE.
- Issue rule: in READ, issue a read at the current address iff `fifo_count + in_flight < FIFO_DEPTH`.
  - `fifo_count` is the registered FIFO occupancy. Same-cycle pops are not credited.
  - `in_flight` is the number of ones in a READ_LATENCY-deep shift register of issued-read flags.
  - On each issue, the address increments by 1. X wraps at WIDTH-1 to 0, and y increments.
- Return path: when the shift-register tail is 1, push `{pixel_in, x, y, last}` into the FIFO. The x/y tag travels with the read through a matching pipe.
- Credit accounting guarantees that a push never finds the FIFO full. A push to a full FIFO is a design error and must be flagged by an assertion in simulation.
- Output: `valid_out` is high iff the FIFO is non-empty. The FIFO head drives `pixel_out`, `pixel_x_out`, `pixel_y_out` and `last_out` directly (first-word fall-through). A pop happens on `valid_out && ready_in`.
- Push and pop in the same cycle leave the count unchanged.
- Output data is held stable while `valid_out && !ready_in`.
- `busy_out` is high in READ and DRAIN.
- Reset (asynchronous, active-low, any time, including mid-frame): return to IDLE and empty the FIFO and pipes. Outputs take their reset values immediately, and in-flight BRAM data is discarded.

## Timing

- Reset values: all outputs 0.
- Cycle 0 is the edge that samples `start_in`.
  - `read_addr=0` and `read_addr_valid=1` in cycle 1.
  - The address issued in cycle k has its data on `pixel_in` in cycle k+READ_LATENCY. It is pushed at the end of that cycle and appears on `valid_out` in cycle k+READ_LATENCY+1.
- With `ready_in` held high and defaults: first `valid_out` in cycle 4, one pixel per cycle, `last_out` in cycle N+3, `done_out` in cycle N+4, where N=WIDTH*HEIGHT.
- Under backpressure, issuing stalls so that at most FIFO_DEPTH pixels are either buffered or in flight. When `ready_in` returns, the first pop happens in that same cycle.
- `busy_out` falls in the same cycle that `done_out` pulses.
- `done_out` is a single-cycle pulse.

## Test plan

- WIDTH=4, HEIGHT=4, BRAM preloaded with addr*3, `ready_in`=1, `start_in` pulse:
  - 16 pixels 0,3,…,45 on consecutive cycles 4..19.
  - x/y raster order.
  - `last_out` only at (3,3).
  - `done_out` at cycle 20.
  - `busy_out` high cycles 1..19.
- Same image, `ready_in` toggling randomly:
  - all 16 pixels in order with no duplicates or drops, and data held while stalled.
  - `read_addr_valid` never issued when buffered+in-flight=4.
- `ready_in`=0 for 30 cycles after start:
  - exactly 4 reads issued, `valid_out` high, `pixel_out`=0 stable.
  - after release, the remaining pixels stream correctly.
- `start_in` pulsed again at cycle 8 mid-frame: ignored, and the output is identical to the first test.
- `rst_in` driven low asynchronously mid-frame at pixel 7: all outputs 0 immediately. A new `start_in` reproduces the full frame from pixel 0.
- `READ_LATENCY`=3, `FIFO_DEPTH`=5, WIDTH=8, HEIGHT=2: first `valid_out` at cycle 5, 16 pixels at full rate, `done_out` at cycle 21.
